// File: rtl/pll_lock_seq_if.sv
// Control/status bundle for the PLL lock sequencer.
// master: the side driving the PLL lock input and the relock request.
// slave:  the sequencer itself.
interface pll_lock_seq_if;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_locked, force_relock,
        input  pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt
    );

    modport slave (
        input  pll_locked, force_relock,
        output pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt
    );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL power-up / relock sequencer.
// Holds the PLL in reset, waits for a synchronized lock, and qualifies it over
// a stability window before releasing sys_rst. Timeouts retry a bounded number
// of times and then park in FAIL until force_relock or rst.
// Optional feature macro: PLL_LOCK_LOSS_CNT_EN builds the saturating
// lock-loss counter; without it lock_loss_cnt is tied to zero.
module pll_lock_seq #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic           refclk,
    input  logic           rst,
    pll_lock_seq_if.slave  bus
);

    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    // Output vector order: {pll_rst, sys_rst, ready, fail}
    localparam logic [3:0] OUT_RESET = 4'b1100;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sync;
    logic             locked_s;
    logic [3:0]       outs;
    logic [3:0]       retry;
    logic             loss_inc;

    assign locked_s = sync[1];

    // Registered output pattern that goes with a state
    function automatic logic [3:0] outs_for(state_t s);
        logic [3:0] o;
        o = OUT_RESET;
        case (s)
            S_RESET_PLL: o = 4'b1100;
            S_WAIT_LOCK: o = 4'b0100;
            S_STABILIZE: o = 4'b0100;
            S_RUN:       o = 4'b0010;
            S_FAIL:      o = 4'b1101;
            default:     o = OUT_RESET;
        endcase
        return o;
    endfunction

    // Lock synchronizer, shared counter, sequencing FSM and its registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state    <= S_RESET_PLL;
            cnt      <= '0;
            sync     <= 2'b00;
            outs     <= OUT_RESET;
            retry    <= 4'd0;
            loss_inc <= 1'b0;
        end else begin
            sync     <= {sync[0], bus.pll_locked};
            loss_inc <= 1'b0;
            if (bus.force_relock) begin
                // Relock request beats every other transition and is never a lock loss
                state <= S_RESET_PLL;
                outs  <= outs_for(S_RESET_PLL);
                cnt   <= '0;
                retry <= 4'd0;
            end else begin
                case (state)
                    S_RESET_PLL: begin
                        if (cnt == RST_LAST) begin
                            state <= S_WAIT_LOCK;
                            outs  <= outs_for(S_WAIT_LOCK);
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_WAIT_LOCK: begin
                        // Lock seen on the timeout cycle still counts as lock
                        if (locked_s) begin
                            state <= S_STABILIZE;
                            outs  <= outs_for(S_STABILIZE);
                            cnt   <= '0;
                        end else if (cnt == TO_LAST) begin
                            cnt <= '0;
                            if (retry == RETRY_MAX) begin
                                state <= S_FAIL;
                                outs  <= outs_for(S_FAIL);
                            end else begin
                                retry <= retry + 4'd1;
                                state <= S_RESET_PLL;
                                outs  <= outs_for(S_RESET_PLL);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_STABILIZE: begin
                        // A drop restarts the lock wait without consuming a retry
                        if (!locked_s) begin
                            state <= S_WAIT_LOCK;
                            outs  <= outs_for(S_WAIT_LOCK);
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state <= S_RUN;
                            outs  <= outs_for(S_RUN);
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (!locked_s) begin
                            state    <= S_RESET_PLL;
                            outs     <= outs_for(S_RESET_PLL);
                            cnt      <= '0;
                            retry    <= 4'd0;
                            loss_inc <= 1'b1;
                        end
                    end
                    S_FAIL: begin
                        state <= S_FAIL;
                    end
                    default: begin
                        state <= S_RESET_PLL;
                        outs  <= outs_for(S_RESET_PLL);
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt;
    logic       loss_now;

    // Lock loss in RUN is flagged on the same edge that leaves RUN
    assign loss_now = (state == S_RUN) && !locked_s && !bus.force_relock;

    // Saturating count of lock losses observed while running
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt <= 8'd0;
        end else if (loss_now && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign bus.lock_loss_cnt = loss_cnt;
`else
    assign bus.lock_loss_cnt = 8'd0;
`endif

    assign bus.pll_rst   = outs[3];
    assign bus.sys_rst   = outs[2];
    assign bus.ready     = outs[1];
    assign bus.fail      = outs[0];
    assign bus.retry_cnt = retry;

    // loss_inc mirrors the loss event for debug visibility; unused otherwise
    logic unused_ok;
    assign unused_ok = loss_inc;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Scoreboard bench for pll_lock_seq: a driver steps a reference model on the
// inputs it applies and queues the expected outputs; a monitor compares them.
module tb_pll_lock_seq;

    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int LTC = 32;
    localparam int MR  = 2;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_FAIL = 4;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fail;
        logic [3:0] retry;
        logic [7:0] loss;
    } exp_t;

    logic refclk = 1'b0;
    logic rst;
    pll_lock_seq_if bus ();

    pll_lock_seq #(
        .PLL_RST_CYCLES      (PRC),
        .LOCK_STABLE_CYCLES  (LSC),
        .LOCK_TIMEOUT_CYCLES (LTC),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 refclk = ~refclk;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    event async_ev;

    // Reference model: phase, time spent in phase, lock history
    int ph, ph_time, m_retry, m_loss;
    bit lk_d1, lk_d2;

    function automatic exp_t model_out();
        exp_t e;
        e.pll_rst = (ph == PH_RST) || (ph == PH_FAIL);
        e.sys_rst = (ph != PH_RUN);
        e.ready   = (ph == PH_RUN);
        e.fail    = (ph == PH_FAIL);
        e.retry   = 4'(m_retry);
        e.loss    = 8'(m_loss);
        return e;
    endfunction

    task automatic model_reset();
        ph = PH_RST; ph_time = 0; m_retry = 0; m_loss = 0;
        lk_d1 = 0; lk_d2 = 0;
    endtask

    task automatic model_step(bit r, bit lk, bit frc);
        int nph;
        bit seen;
        if (r) begin
            model_reset();
            return;
        end
        seen  = lk_d2;          // lock as seen after two refclk stages
        lk_d2 = lk_d1;
        lk_d1 = lk;
        nph   = ph;
        if (frc) begin
            nph = PH_RST;
            m_retry = 0;
        end else if (ph == PH_RST) begin
            if (ph_time == PRC - 1) nph = PH_WAIT;
        end else if (ph == PH_WAIT) begin
            if (seen) nph = PH_STAB;
            else if (ph_time == LTC - 1) begin
                if (m_retry == MR) nph = PH_FAIL;
                else begin
                    m_retry++;
                    nph = PH_RST;
                end
            end
        end else if (ph == PH_STAB) begin
            if (!seen) nph = PH_WAIT;
            else if (ph_time == LSC - 1) nph = PH_RUN;
        end else if (ph == PH_RUN) begin
            if (!seen) begin
                nph = PH_RST;
                m_retry = 0;
`ifdef PLL_LOCK_LOSS_CNT_EN
                if (m_loss < 255) m_loss++;
`endif
            end
        end
        ph_time = (frc || nph != ph) ? 0 : ph_time + 1;
        ph = nph;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expectation
    task automatic cyc(bit r, bit lk, bit frc);
        @(negedge refclk);
        rst = r;
        bus.pll_locked   = lk;
        bus.force_relock = frc;
        model_step(r, lk, frc);
        sb_q.push_back(model_out());
    endtask

    task automatic hold(bit lk, int n);
        for (int i = 0; i < n; i++) cyc(1'b0, lk, 1'b0);
    endtask

    // Monitor: compare queued expectation with DUT outputs, away from the edge
    initial begin
        exp_t e, got;
        forever begin
            @(posedge refclk or async_ev);
            #2;
            cyc_n++;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {bus.pll_rst, bus.sys_rst, bus.ready, bus.fail,
                       bus.retry_cnt, bus.lock_loss_cnt};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d loss=%0d want pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d loss=%0d",
                             $time, got.pll_rst, got.sys_rst, got.ready, got.fail, got.retry, got.loss,
                             e.pll_rst, e.sys_rst, e.ready, e.fail, e.retry, e.loss);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: stimulus did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Stimulus
    initial begin
        int guard;
        int len;
        bit lk;
        rst = 1'b1;
        bus.pll_locked   = 1'b0;
        bus.force_relock = 1'b0;
        model_reset();

        // Reset state
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);

        // Clean lock: lock rises 10 cycles after release
        hold(1'b0, 10);
        hold(1'b1, 30);

        // Lock loss in RUN for 20 cycles, then recovery
        hold(1'b0, 20);
        hold(1'b1, 30);

        // Timeout to FAIL with lock held low, then parked
        guard = 0;
        while (ph != PH_FAIL && guard < 400) begin
            cyc(1'b0, 1'b0, 1'b0);
            guard++;
        end
        total++;
        if (ph != PH_FAIL) begin
            bad++;
            $display("FAIL reach_fail: phase=%0d after %0d cycles, required FAIL", ph, guard);
        end
        hold(1'b0, 40);

        // Recovery from FAIL with force_relock, then async reset mid-STABILIZE
        cyc(1'b0, 1'b1, 1'b1);
        guard = 0;
        while (!(ph == PH_STAB && ph_time >= 3) && guard < 100) begin
            cyc(1'b0, 1'b1, 1'b0);
            guard++;
        end
        total++;
        if (ph != PH_STAB) begin
            bad++;
            $display("FAIL reach_stabilize: phase=%0d, required STABILIZE", ph);
        end
        @(posedge refclk);
        #3;
        rst = 1'b1;
        model_reset();
        sb_q.push_back(model_out());
        -> async_ev;
        cyc(1'b1, 1'b1, 1'b0);

        // Glitchy lock: 5 high, 3 low, then high, once in WAIT_LOCK
        hold(1'b0, 8);
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 30);

        // Randomized segments with occasional relock requests
        for (int s = 0; s < 40; s++) begin
            lk  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                cyc(1'b0, lk, ($urandom_range(0, 49) == 0));
        end

        // Reach RUN, then 260 lock losses to saturate the counter
        hold(1'b1, 40);
        for (int n = 0; n < 260; n++) begin
            hold(1'b0, 3);
            hold(1'b1, 24);
        end

        @(posedge refclk);
        #3;
        total++;
`ifdef PLL_LOCK_LOSS_CNT_EN
        if (bus.lock_loss_cnt !== 8'd255) begin
            bad++;
            $display("FAIL loss_saturate: got %0d required 255", bus.lock_loss_cnt);
        end
`else
        if (bus.lock_loss_cnt !== 8'd0) begin
            bad++;
            $display("FAIL loss_tied_off: got %0d required 0", bus.lock_loss_cnt);
        end
`endif
        @(posedge refclk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
